// File: rtl/sequence_stats.sv
// sequence_stats: collects count, sum, min, max and step-error statistics
// over one generator run and presents them as a valid/ready result record.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   sample_valid     sample enable from the generator
//   sequence_value   signed sample
//   done             generator end-of-sequence pulse
//   expected_step    signed step, latched on the first sample of a run
//   result_ready     consumer accepts the record
//   result_valid     record valid (REPORT state)
//   count, sum       saturating sample count, wrapping signed sum
//   min_value        signed minimum sample
//   max_value        signed maximum sample
//   step_errors      saturating count of step mismatches
//   dropped          a sample arrived while the record was pending
//   timed_out        run ended by the idle timeout
//
// Optional feature: define SEQ_STATS_TIMEOUT_EN to end a run after
// TIMEOUT_CYCLES consecutive idle cycles in COLLECT. Without it the
// timeout counter is not built and timed_out is tied to 0.
module sequence_stats #(
    parameter int DATA_W         = 32,
    parameter int SUM_W          = 48,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sequence_value,
    input  logic                     done,
    input  logic signed [DATA_W-1:0] expected_step,
    input  logic                     result_ready,
    output logic                     result_valid,
    output logic        [CNT_W-1:0]  count,
    output logic signed [SUM_W-1:0]  sum,
    output logic signed [DATA_W-1:0] min_value,
    output logic signed [DATA_W-1:0] max_value,
    output logic        [CNT_W-1:0]  step_errors,
    output logic                     dropped,
    output logic                     timed_out
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT
    } state_t;

    localparam logic signed [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic        [CNT_W-1:0]  CNT_MAX = '1;

    state_t state;
    state_t state_next;

    logic signed [DATA_W-1:0] prev;
    logic signed [DATA_W-1:0] step;
    logic signed [DATA_W:0]   diff;
    logic signed [SUM_W-1:0]  sample_ext;
    logic                     step_bad;
    logic                     timeout_hit;

    // One extra bit keeps the difference of any two samples exact.
    assign diff = {sequence_value[DATA_W-1], sequence_value}
                - {prev[DATA_W-1], prev};
    assign step_bad = diff != {step[DATA_W-1], step};
    assign sample_ext = {{(SUM_W-DATA_W){sequence_value[DATA_W-1]}},
                         sequence_value};

`ifdef SEQ_STATS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          timed_out_q;

    // Counts consecutive sample-free cycles spent in COLLECT.
    always_ff @(posedge clk) begin
        if (rst || state != COLLECT || sample_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // done on the same cycle takes priority, so the run is not a timeout.
    assign timeout_hit = state == COLLECT && !sample_valid && !done
                      && idle_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            timed_out_q <= 1'b0;
        end else if (state == IDLE && (sample_valid || done)) begin
            timed_out_q <= 1'b0;
        end else if (timeout_hit) begin
            timed_out_q <= 1'b1;
        end
    end

    assign timed_out = timed_out_q;
`else
    // No timeout hardware; never true for a legal TIMEOUT_CYCLES.
    assign timeout_hit = TIMEOUT_CYCLES < 0;
    assign timed_out   = 1'b0;
`endif

    assign result_valid = state == REPORT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (sample_valid) begin
                    state_next = done ? REPORT : COLLECT;
                end else if (done) begin
                    state_next = REPORT;
                end
            end
            COLLECT: begin
                if (done || timeout_hit) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            sum         <= '0;
            min_value   <= POS_MAX;
            max_value   <= NEG_MAX;
            step_errors <= '0;
            dropped     <= 1'b0;
            prev        <= '0;
            step        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sample_valid) begin
                        count       <= CNT_W'(1);
                        sum         <= sample_ext;
                        min_value   <= sequence_value;
                        max_value   <= sequence_value;
                        step_errors <= '0;
                        dropped     <= 1'b0;
                        prev        <= sequence_value;
                        step        <= expected_step;
                    end else if (done) begin
                        // Empty run: report the neutral record.
                        count       <= '0;
                        sum         <= '0;
                        min_value   <= POS_MAX;
                        max_value   <= NEG_MAX;
                        step_errors <= '0;
                        dropped     <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (sample_valid) begin
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        sum <= sum + sample_ext;
                        if (sequence_value < min_value) begin
                            min_value <= sequence_value;
                        end
                        if (sequence_value > max_value) begin
                            max_value <= sequence_value;
                        end
                        if (step_bad && step_errors != CNT_MAX) begin
                            step_errors <= step_errors + 1'b1;
                        end
                        prev <= sequence_value;
                    end
                end
                REPORT: begin
                    if (sample_valid) begin
                        dropped <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_stats.sv
// tb_sequence_stats: directed test of sequence_stats against a run-level
// model built from the list of samples accepted in the current run.
module tb_sequence_stats;

    localparam int TO = 8;

    logic               clk;
    logic               rst;
    logic               sample_valid;
    logic signed [31:0] sequence_value;
    logic               done;
    logic signed [31:0] expected_step;
    logic               result_ready;
    logic               result_valid;
    logic        [15:0] count;
    logic signed [47:0] sum;
    logic signed [31:0] min_value;
    logic signed [31:0] max_value;
    logic        [15:0] step_errors;
    logic               dropped;
    logic               timed_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    sequence_stats #(
        .DATA_W(32),
        .SUM_W(48),
        .CNT_W(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sequence_value(sequence_value),
        .done(done),
        .expected_step(expected_step),
        .result_ready(result_ready),
        .result_valid(result_valid),
        .count(count),
        .sum(sum),
        .min_value(min_value),
        .max_value(max_value),
        .step_errors(step_errors),
        .dropped(dropped),
        .timed_out(timed_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    // Model: phase 0 idle, 1 collecting, 2 reporting; run = sample list.
    int     ph = 0;
    longint smp[$];
    longint m_step = 0;
    bit     m_drop = 0;
    bit     m_to = 0;
    int     m_idle = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
            smp.delete();
            m_drop = 0;
            m_to = 0;
            m_idle = 0;
        end else begin
            case (ph)
                0: begin
                    if (sample_valid || done) begin
                        smp.delete();
                        m_drop = 0;
                        m_to = 0;
                        m_idle = 0;
                        if (sample_valid) begin
                            smp.push_back(sx(sequence_value));
                            m_step = sx(expected_step);
                        end
                        ph = (done || !sample_valid) ? 2 : 1;
                    end
                end
                1: begin
                    if (sample_valid) begin
                        smp.push_back(sx(sequence_value));
                        m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                    if (done) begin
                        ph = 2;
                    end
`ifdef SEQ_STATS_TIMEOUT_EN
                    else if (m_idle == TO) begin
                        ph = 2;
                        m_to = 1;
                    end
`endif
                end
                default: begin
                    if (sample_valid) m_drop = 1;
                    if (result_ready) ph = 0;
                end
            endcase
        end
    end

    function automatic void rec(output longint c, output longint s,
                                output longint mn, output longint mx,
                                output longint e);
        longint acc;
        logic signed [47:0] t;
        c = (smp.size() > 65535) ? 65535 : smp.size();
        acc = 0;
        mn = 64'sd2147483647;
        mx = -64'sd2147483648;
        e = 0;
        foreach (smp[i]) begin
            acc += smp[i];
            if (smp[i] < mn) mn = smp[i];
            if (smp[i] > mx) mx = smp[i];
            if (i > 0 && smp[i] - smp[i-1] != m_step && e < 65535) e++;
        end
        t = acc[47:0];
        s = longint'(t);
    endfunction

    always @(negedge clk) begin
        longint c, s, mn, mx, e;
        if (chk_en) begin
            rec(c, s, mn, mx, e);
            chk("cyc_result_valid", longint'(result_valid), longint'(ph == 2));
            chk("cyc_count", longint'(count), c);
            chk("cyc_sum", longint'(sum), s);
            chk("cyc_min", longint'(min_value), mn);
            chk("cyc_max", longint'(max_value), mx);
            chk("cyc_step_errors", longint'(step_errors), e);
            chk("cyc_dropped", longint'(dropped), longint'(m_drop));
            chk("cyc_timed_out", longint'(timed_out), longint'(m_to));
        end
    end

    // Apply inputs, then wait for the negedge after the sampling edge.
    task automatic drive(input bit sv, input longint v, input bit dn,
                         input bit rdy);
        sample_valid = sv;
        sequence_value = v[31:0];
        done = dn;
        result_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst = 1;
        sample_valid = 0;
        sequence_value = 0;
        done = 0;
        expected_step = 0;
        result_ready = 0;
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("reset_valid", longint'(result_valid), 0);
        chk("reset_count", longint'(count), 0);
        chk("reset_min", longint'(min_value), 64'sd2147483647);
        chk("reset_max", longint'(max_value), -64'sd2147483648);
        chk_en = 1;
        rst = 0;
        drive(0, 0, 0, 0);

        // Normal run
        expected_step = 3;
        drive(1, 10, 0, 1);
        drive(1, 13, 0, 1);
        drive(1, 16, 0, 1);
        drive(1, 19, 1, 1);
        chk("t1_valid", longint'(result_valid), 1);
        chk("t1_count", longint'(count), 4);
        chk("t1_sum", longint'(sum), 58);
        chk("t1_min", longint'(min_value), 10);
        chk("t1_max", longint'(max_value), 19);
        chk("t1_err", longint'(step_errors), 0);
        chk("t1_drop", longint'(dropped), 0);
        drive(0, 0, 0, 1);
        chk("t1_hs", longint'(result_valid), 0);

        // Back-to-back: negative values with one step error
        expected_step = -5;
        drive(1, 0, 0, 1);
        drive(1, -5, 0, 1);
        drive(1, -9, 0, 1);
        drive(1, -14, 1, 1);
        chk("t2_count", longint'(count), 4);
        chk("t2_sum", longint'(sum), -28);
        chk("t2_min", longint'(min_value), -14);
        chk("t2_max", longint'(max_value), 0);
        chk("t2_err", longint'(step_errors), 1);
        drive(0, 0, 0, 1);

        // Extreme-value difference
        expected_step = 1;
        drive(1, 64'h7FFFFFFF, 0, 1);
        drive(1, 64'h80000000, 1, 1);
        chk("t3_err", longint'(step_errors), 1);
        chk("t3_min", longint'(min_value), -64'sd2147483648);
        chk("t3_max", longint'(max_value), 64'sd2147483647);
        chk("t3_sum", longint'(sum), -1);
        drive(0, 0, 0, 1);

        // Backpressure with drops and an ignored done
        drive(1, 1, 0, 0);
        drive(1, 2, 1, 0);
        for (int i = 0; i < 5; i++) drive(i % 2 == 0, 99, i == 2, 0);
        chk("t4_valid", longint'(result_valid), 1);
        chk("t4_count", longint'(count), 2);
        chk("t4_sum", longint'(sum), 3);
        chk("t4_drop", longint'(dropped), 1);
        drive(0, 0, 0, 1);
        chk("t4_idle_valid", longint'(result_valid), 0);
        chk("t4_idle_drop", longint'(dropped), 1);
        drive(1, 5, 0, 1);
        chk("t4_new_drop", longint'(dropped), 0);
        chk("t4_new_count", longint'(count), 1);
        drive(1, 6, 1, 1);
        drive(0, 0, 0, 1);

        // Reset mid-run
        drive(1, 7, 0, 0);
        drive(1, 8, 0, 0);
        rst = 1;
        drive(0, 0, 0, 0);
        rst = 0;
        chk("t5_valid", longint'(result_valid), 0);
        chk("t5_count", longint'(count), 0);
        chk("t5_sum", longint'(sum), 0);
        chk("t5_min", longint'(min_value), 64'sd2147483647);
        drive(0, 0, 0, 0);
        chk("t5_still_idle", longint'(result_valid), 0);

        // Empty run
        drive(0, 0, 1, 0);
        chk("t6_valid", longint'(result_valid), 1);
        chk("t6_count", longint'(count), 0);
        chk("t6_sum", longint'(sum), 0);
        drive(0, 0, 0, 1);

        // Timeout behaviour
        expected_step = 2;
        drive(1, 1, 0, 1);
        drive(1, 3, 0, 1);
        seen = 0;
`ifdef SEQ_STATS_TIMEOUT_EN
        for (int i = 0; i < 30 && !seen; i++) begin
            drive(0, 0, 0, 0);
            if (result_valid) seen = 1;
        end
        chk("t7_seen", longint'(seen), 1);
        chk("t7_timed_out", longint'(timed_out), 1);
        chk("t7_count", longint'(count), 2);
        drive(0, 0, 0, 1);
`else
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0);
            if (result_valid) seen = 1;
        end
        chk("t7_no_result", longint'(seen), 0);
        drive(0, 0, 1, 0);
        chk("t7_done_valid", longint'(result_valid), 1);
        chk("t7_timed_out", longint'(timed_out), 0);
        drive(0, 0, 0, 1);
`endif
        drive(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_stats.md
Name: sequence_stats

Overview:
- Downstream consumer of the sequence generator: samples `sequence_value` on every enabled cycle until the generator signals `done`.
- Accumulates count, sum, min and max, and checks that consecutive samples differ by the expected step.
- Presents one result record per run over a valid/ready handshake to the testbench scoreboard or a host register block.

Parameters:
- DATA_W, 32: width of signed sample and step.
- SUM_W, 48: width of signed running sum.
- CNT_W, 16: width of sample and error counters.
- TIMEOUT_CYCLES, 1024: idle-cycle limit in COLLECT; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- sample_valid  input  1  generator enable; sample is taken when high.
- sequence_value  input  DATA_W  signed sample from the generator.
- done  input  1  generator end-of-sequence pulse.
- expected_step  input  DATA_W  signed step the generator was programmed with.
- result_ready  input  1  consumer accepts the result.
- result_valid  output  1  result record is valid.
- count  output  CNT_W  number of samples accepted, saturating.
- sum  output  SUM_W  signed sum of samples, wraps modulo 2^SUM_W.
- min_value  output  DATA_W  signed minimum sample.
- max_value  output  DATA_W  signed maximum sample.
- step_errors  output  CNT_W  count of step mismatches, saturating.
- dropped  output  1  a sample arrived while in REPORT.
- timed_out  output  1  run ended by timeout; constant 0 when the feature is absent.

Behaviour:
- Reset, synchronous, wins over all other inputs:
  - state=IDLE.
  - All outputs 0, except min_value = most positive DATA_W value and max_value = most negative DATA_W value.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE:
  - sample_valid=1 → load count=1, sum=sign-extended sample, min=max=sample, prev=sample, step_errors=0, dropped=0, timed_out=0.
  - expected_step is latched on that same cycle. Go to COLLECT, or to REPORT if done is also high.
  - done without sample_valid in IDLE → REPORT with count=0 (empty run).
- COLLECT, each sample_valid=1:
  - count += 1, saturating at 2^CNT_W-1.
  - sum += sign-extended sample.
  - min/max update with signed compare.
  - diff = sample - prev, computed at DATA_W+1 bits, no overflow. If diff != sign-extended latched step, step_errors += 1 (saturating).
  - prev = sample.
- COLLECT, done=1: that cycle's sample, if any, is accumulated first; next state REPORT.
- REPORT:
  - result_valid=1; all result outputs held stable.
  - On result_valid & result_ready → IDLE next cycle. result_valid drops, result outputs keep their values until the next run starts.
  - sample_valid in REPORT: sample is discarded and dropped=1 (sticky until the next run loads).
  - done in REPORT: ignored.
- Latency: result_valid rises exactly 1 cycle after the done cycle.
- Back-to-back runs: a sample in the IDLE cycle immediately after the handshake starts the new run.
- Reset mid-run or in REPORT: aborts immediately; no partial result is emitted.

Optional Feature:
- Macro: SEQ_STATS_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT, clears on every sample_valid, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES with no done → REPORT with timed_out=1.
  - done and timeout on the same cycle → done wins, timed_out=0.
- Not defined: no counter is built; timed_out is tied 0; COLLECT waits indefinitely for done.

Test Plan:
- Normal run:
  - Stimulus: step=3, samples 10,13,16,19 with done on sample 19, result_ready=1.
  - Response: result_valid 1 cycle later; count=4, sum=58, min=10, max=19, step_errors=0, dropped=0.
- Negative values and step errors:
  - Stimulus: step=-5, samples 0,-5,-9,-14 then done.
  - Response: count=4, sum=-28, min=-14, max=0, step_errors=1.
- Extreme-value diff:
  - Stimulus: step=1, samples 0x7FFFFFFF then 0x80000000.
  - Response: step_errors=1 (diff computed without overflow); min=-2147483648, max=2147483647.
- Backpressure:
  - Stimulus: result_ready held 0 for 5 cycles with sample_valid pulses during REPORT.
  - Response: outputs stable, dropped=1, count unchanged; after ready=1, IDLE, and the next run clears dropped.
- Reset mid-run and empty run:
  - Stimulus: rst after 2 samples.
  - Response: all outputs at reset values, no result_valid.
  - Stimulus: done alone in IDLE.
  - Response: result_valid with count=0, sum=0.
- Timeout (SEQ_STATS_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: 2 samples then silence.
  - Response: result_valid with timed_out=1, count=2.
  - Without the macro: no result after 100 idle cycles.
